// File: rtl/dmem_port.sv
// dmem_port: arbitrates stack and load/store requests onto one single-ported synchronous data SRAM.
// Optional macro DMEM_BOUNDS_CHK_EN suppresses and flags accesses at or beyond DMEM_DEPTH.
module dmem_port #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          st_req,
  input  logic                          st_wr,
  input  logic [ADDR_W-1:0]             st_addr,
  input  logic [DATA_W-1:0]             st_wdata,
  input  logic                          ls_req,
  input  logic                          ls_wr,
  input  logic [ADDR_W-1:0]             ls_addr,
  input  logic [DATA_W-1:0]             ls_wdata,
  output logic                          ls_stall,
  output logic                          mem_cen,
  output logic                          mem_wen,
  output logic [$clog2(DMEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          rvalid,
  output logic                          rsrc,
  output logic [DATA_W-1:0]             rdata,
  output logic                          fault
);
  localparam int AW = $clog2(DMEM_DEPTH);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t              state, state_nxt;
  logic                hold_wr;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_wdata;
  logic                cap;
  logic                sel_v, sel_wr, sel_src;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                oob, go;
  logic                rd_pend, rd_src, rd_oob;
  // Stack always wins; a parked load/store replays on the first cycle the stack is quiet.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    sel_v     = 1'b0;
    sel_wr    = 1'b0;
    sel_src   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (st_req) begin
      sel_v     = 1'b1;
      sel_wr    = st_wr;
      sel_src   = 1'b1;
      sel_addr  = st_addr;
      sel_wdata = st_wdata;
      cap       = (state == IDLE) && ls_req;
      state_nxt = cap ? HOLD : state;
    end else if (state == HOLD) begin
      sel_v     = 1'b1;
      sel_wr    = hold_wr;
      sel_addr  = hold_addr;
      sel_wdata = hold_wdata;
      state_nxt = IDLE;
    end else if (ls_req) begin
      sel_v     = 1'b1;
      sel_wr    = ls_wr;
      sel_addr  = ls_addr;
      sel_wdata = ls_wdata;
    end
  end
`ifdef DMEM_BOUNDS_CHK_EN
  assign oob = sel_v && ({1'b0, sel_addr} >= (ADDR_W+1)'(DMEM_DEPTH));
`else
  assign oob = 1'b0;
`endif
  assign go        = sel_v & ~oob;
  assign mem_cen   = go;
  assign mem_wen   = go & sel_wr;
  assign mem_addr  = go ? sel_addr[AW-1:0] : '0;
  assign mem_wdata = go ? sel_wdata : '0;
  assign ls_stall  = (state == HOLD);
  assign rvalid    = rd_pend;
  assign rsrc      = rd_src;
  assign rdata     = (rd_pend && !rd_oob) ? mem_rdata : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      hold_wr    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      rd_pend    <= 1'b0;
      rd_src     <= 1'b0;
      rd_oob     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        hold_wr    <= ls_wr;
        hold_addr  <= ls_addr;
        hold_wdata <= ls_wdata;
      end
      rd_pend <= sel_v & ~sel_wr;
      rd_src  <= (sel_v & ~sel_wr) ? sel_src : rd_src;
      rd_oob  <= oob & ~sel_wr;
    end
  end
`ifdef DMEM_BOUNDS_CHK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) fault_q <= 1'b0;
    else         fault_q <= oob;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed and random checks of dmem_port against a transaction-level model.
module tb_dmem_port;
  localparam int DEPTH = 256;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        st_req = 1'b0, st_wr = 1'b0, ls_req = 1'b0, ls_wr = 1'b0;
  logic [15:0] st_addr = '0, st_wdata = '0, ls_addr = '0, ls_wdata = '0;
  logic        ls_stall, mem_cen, mem_wen, rvalid, rsrc, fault;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, rdata;
  logic [15:0] mem_rdata = '0;
  logic [15:0] sram [DEPTH];

  dmem_port #(.DATA_W(16), .ADDR_W(16), .DMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .st_req(st_req), .st_wr(st_wr), .st_addr(st_addr), .st_wdata(st_wdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_stall(ls_stall), .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rvalid(rvalid), .rsrc(rsrc), .rdata(rdata), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_cen) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      else         mem_rdata <= sram[mem_addr];
    end

  // Model: memory image, one parked load/store, and the response expected this cycle.
  logic [15:0] ref_mem [DEPTH];
  logic        p_v = 1'b0, p_wr = 1'b0;
  logic [15:0] p_addr = '0, p_wdata = '0;
  logic        e_rv = 1'b0, e_src = 1'b0, e_fault = 1'b0;
  logic [15:0] e_rdata = '0;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic sr, input logic sw, input logic [15:0] sa, input logic [15:0] sd,
                      input logic lr, input logic lw, input logic [15:0] la, input logic [15:0] ld);
    logic v, wr, src, oob;
    logic [15:0] a, d;
    logic [7:0] ia;
    st_req = sr; st_wr = sw; st_addr = sa; st_wdata = sd;
    ls_req = lr; ls_wr = lw; ls_addr = la; ls_wdata = ld;
    #1;
    chk("ls_stall", ls_stall, p_v);
    chk("rvalid", rvalid, e_rv);
    if (e_rv) chk("rsrc", rsrc, e_src);
    chk("rdata", rdata, e_rv ? e_rdata : 16'h0);
    chk("fault", fault, e_fault);
    v = 1'b0; wr = 1'b0; src = 1'b0; a = '0; d = '0;
    if (sr) begin
      v = 1'b1; wr = sw; src = 1'b1; a = sa; d = sd;
      if (lr && !p_v) begin p_v = 1'b1; p_wr = lw; p_addr = la; p_wdata = ld; end
    end else if (p_v) begin
      v = 1'b1; wr = p_wr; a = p_addr; d = p_wdata; p_v = 1'b0;
    end else if (lr) begin
      v = 1'b1; wr = lw; a = la; d = ld;
    end
`ifdef DMEM_BOUNDS_CHK_EN
    oob = v && (a >= 16'(DEPTH));
`else
    oob = 1'b0;
`endif
    ia = 8'(a % DEPTH);
    chk("mem_cen", mem_cen, v && !oob);
    chk("mem_wen", mem_wen, v && !oob && wr);
    chk("mem_addr", mem_addr, (v && !oob) ? ia : 8'h0);
    chk("mem_wdata", mem_wdata, (v && !oob) ? d : 16'h0);
    e_rv = v && !wr;
    if (e_rv) begin e_src = src; e_rdata = oob ? 16'h0 : ref_mem[ia]; end
    e_fault = oob;
    if (v && wr && !oob) ref_mem[ia] = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    st_req = 0; st_wr = 0; ls_req = 0; ls_wr = 0;
    resetn = 1'b0;
    #1;
    chk("rst_stall", ls_stall, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cen", mem_cen, 0);
    p_v = 1'b0; e_rv = 1'b0; e_fault = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    int n;
    logic [15:0] ra;
    do_reset();
    for (int i = 0; i < 32; i++) step(1, 1, 16'(i), 16'($urandom), 0, 0, 0, 0);
    step(1, 1, 16'h0010, 16'hBEEF, 0, 0, 0, 0);
    step(1, 1, 16'h0020, 16'hAAAA, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 16'h0030, 16'h5555);
    idle();
    // Plain load/store read
    step(0, 0, 0, 0, 1, 0, 16'h0010, 0);
    chk("t1_rvalid", rvalid, 1);
    chk("t1_rsrc", rsrc, 0);
    chk("t1_rdata", rdata, 16'hBEEF);
    chk("t1_stall", ls_stall, 0);
    idle();
    // Stack write then read back
    step(1, 1, 16'h00FF, 16'h1234, 0, 0, 0, 0);
    step(1, 0, 16'h00FF, 0, 0, 0, 0, 0);
    chk("t2_rsrc", rsrc, 1);
    chk("t2_rdata", rdata, 16'h1234);
    idle();
    // Simple collision
    step(1, 0, 16'h0020, 0, 1, 0, 16'h0030, 0);
    chk("t3_st_rdata", rdata, 16'hAAAA);
    chk("t3_st_rsrc", rsrc, 1);
    chk("t3_stall", ls_stall, 1);
    idle();
    chk("t3_ls_rdata", rdata, 16'h5555);
    chk("t3_ls_rsrc", rsrc, 0);
    chk("t3_stall_off", ls_stall, 0);
    idle();
    // Collision held by three stack cycles; a stack write to the parked read address lands first
    n = 0;
    step(1, 0, 16'h0001, 0, 1, 0, 16'h0002, 0);  n += int'(ls_stall);
    step(1, 1, 16'h0002, 16'hC0DE, 0, 0, 0, 0);  n += int'(ls_stall);
    step(1, 0, 16'h0003, 0, 0, 0, 0, 0);         n += int'(ls_stall);
    step(1, 0, 16'h0004, 0, 0, 0, 0, 0);         n += int'(ls_stall);
    idle();                                      n += int'(ls_stall);
    chk("t4_stall_cycles", n, 4);
    chk("t4_rsrc", rsrc, 0);
    chk("t4_rdata", rdata, 16'hC0DE);
    idle();
    // Reset while holding
    step(1, 0, 16'h0001, 0, 1, 0, 16'h0003, 0);
    chk("t5_hold", ls_stall, 1);
    do_reset();
    idle();
    idle();
    // Address beyond the SRAM
    step(0, 0, 0, 0, 1, 0, 16'h0100, 0);
    chk("t6_rvalid", rvalid, 1);
`ifdef DMEM_BOUNDS_CHK_EN
    chk("t6_fault", fault, 1);
    chk("t6_rdata", rdata, 16'h0);
`else
    chk("t6_fault", fault, 0);
    chk("t6_rdata", rdata, ref_mem[0]);
`endif
    idle();
    // Random traffic obeying ls_stall
    for (int i = 0; i < 400; i++) begin
      logic sr, sw, lr, lw;
      logic [15:0] sa, la;
      sr = 1'($urandom_range(0, 1));
      sw = 1'($urandom_range(0, 1));
      lr = p_v ? 1'b0 : 1'($urandom_range(0, 1));
      lw = 1'($urandom_range(0, 1));
      ra = 16'($urandom_range(0, 31));
      sa = ($urandom_range(0, 7) == 0) ? ra + 16'h0100 : ra;
      ra = 16'($urandom_range(0, 31));
      la = ($urandom_range(0, 7) == 0) ? ra + 16'h0100 : ra;
      step(sr, sw, sa, 16'($urandom), lr, lw, la, 16'($urandom));
    end
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_port.md
# dmem_port

Data-memory port for the 16-bit processor. It sits directly downstream of the stack unit and the normal load/store path in EX, and arbitrates their requests onto one single-ported synchronous data SRAM. Stack traffic has priority, so push/pop sequences of register lists and LR never stall. A colliding load/store is parked in a one-entry hold buffer and replayed, and read data returns one cycle after issue, tagged with its source.

## Interface
- DATA_W, 16, data word width
- ADDR_W, 16, request address width
- DMEM_DEPTH, 256, SRAM depth in words (power of two)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- st_req  in  1  stack unit memory request (stack unit's force signal)
- st_wr  in  1  stack request is a write
- st_addr  in  ADDR_W  stack word address
- st_wdata  in  DATA_W  stack write data
- ls_req  in  1  load/store request from EX
- ls_wr  in  1  load/store is a write
- ls_addr  in  ADDR_W  load/store word address
- ls_wdata  in  DATA_W  load/store write data
- ls_stall  out  1  hold buffer occupied; EX must not present a new ls_req
- mem_cen  out  1  SRAM chip enable, active high
- mem_wen  out  1  SRAM write enable, active high
- mem_addr  out  log2(DMEM_DEPTH)  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read enable
- rvalid  out  1  read data valid
- rsrc  out  1  source of rdata: 0 = load/store, 1 = stack
- rdata  out  DATA_W  read data
- fault  out  1  out-of-range access pulse (DMEM_BOUNDS_CHK_EN only)

## Operation
- Two states: IDLE (buffer empty) and HOLD (buffer holds one load/store).
- IDLE, st_req only: issue stack access.
- IDLE, ls_req only: issue load/store.
- IDLE, st_req and ls_req together: issue stack access, capture ls_wr/addr/wdata into the buffer, go to HOLD.
- HOLD, st_req=1: issue stack access; the buffer is kept.
- HOLD, st_req=0: issue the buffered access and return to IDLE.
- Any ls_req in HOLD is a protocol violation and is ignored.
- Issue path (combinational from the selected source): mem_cen=1, mem_wen=wr, mem_addr=addr[log2(DMEM_DEPTH)-1:0], mem_wdata=wdata. With no issue, all mem_* outputs are 0.
- Reads: a one-entry pipeline register records the read and its source. The next cycle drives rvalid=1, rsrc=source, rdata=mem_rdata.
- Writes produce no response.
- ls_stall = (state==HOLD), registered.

## Timing
- Reset values: state IDLE, buffer invalid, ls_stall 0, rvalid 0, rsrc 0, fault 0. rdata is 0 while rvalid=0.
- Read latency is exactly 1 cycle from issue to rvalid. Back-to-back reads give rvalid on consecutive cycles.
- A collision costs the load/store at least one extra cycle. Its response arrives ≥2 cycles after presentation.
- ls_stall rises the cycle after a collision and falls the cycle after the buffered access issues.
- Reset mid-operation discards the buffer and any pending rvalid; no replay occurs after reset.
- A stack write and a buffered read to the same address: the stack write issues first, so the read returns the new data.

## Configuration
- DMEM_BOUNDS_CHK_EN defined:
  - A selected access with addr ≥ DMEM_DEPTH does not assert mem_cen.
  - fault pulses high for 1 cycle, the cycle after issue.
  - A read still returns rvalid=1 with rdata=0.
- DMEM_BOUNDS_CHK_EN undefined:
  - Upper address bits are dropped (wrap-around).
  - fault is tied to 0.

## Test plan
- Reset, then ls read at 0x0010 holding 0xBEEF -> next cycle rvalid=1, rsrc=0, rdata=0xBEEF; ls_stall stays 0.
- Stack write 0x1234 to 0x00FF, then stack read 0x00FF -> mem_wen=1 on the first cycle; rvalid with rdata=0x1234, rsrc=1 two cycles after the write.
- Same cycle: st read 0x0020 (=0xAAAA) and ls read 0x0030 (=0x5555) -> rvalid rsrc=1 0xAAAA, then rvalid rsrc=0 0x5555 one cycle later; ls_stall high exactly 1 cycle.
- Collision followed by 3 consecutive st_req cycles -> ls_stall held 4 cycles, buffered access issues in the 5th; response data correct.
- resetn asserted while in HOLD -> after release, state IDLE, ls_stall=0, rvalid=0, no buffered SRAM access seen.
- DMEM_BOUNDS_CHK_EN set, ls read at 0x0100 (DEPTH 256) -> mem_cen stays 0, next cycle fault=1, rvalid=1, rdata=0. Without the macro -> mem_addr=0x00, data from word 0.
